cook_sequencer: RTL and testbench

Top-level sequencing FSM for the microwave controller. It sits above the mm:ss timer chain of cascaded BCD down-counters, including the MOD6 seconds-tens stage. It collects keypad digits into a 4-digit mm:ss preset and issues the timer's load, clear and count-enable strobes from an internal 1-second prescaler. It gates the magnetron and handles door, pause, stop/clear and cook-done.

---
 rtl/cook_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/cook_sequencer.sv | 150 +++++++++++++++
 tb/tb_cook_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook sequencer.
package cook_pkg;

    // Sequencer state encodings; codes 5-7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Largest legal seconds-tens digit (the timer's MOD6 stage).
    localparam bcd_digit_t SEC_TENS_MAX  = 4'd5;
    // Keypad codes above this are non-digit keys.
    localparam bcd_digit_t KEY_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing the 1 s tick; supports clear and hold.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q, count_d;

    // Clear wins over count; without en the value is held.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High while the counter sits at its terminal value; the user gates it with en.
    assign tc = (count_q == CNT_MAX);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave top-level sequencer: keypad entry, timer strobes, magnetron gating.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int DONE_HOLD = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        timer_zero,
    output logic [15:0] entry,
    output logic        timer_loadn,
    output logic        timer_clrn,
    output logic        timer_enable,
    output logic        magnetron,
    output logic        done_flag,
    output logic [2:0]  state
);

    localparam int HW = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    state_e        state_q, state_d;
    logic [15:0]   entry_q, entry_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          loadn_q, loadn_d;
    logic          clrn_q, clrn_d;
    logic          tmr_en_q, tmr_en_d;
    logic          mag_q, mag_d;
    logic          done_q, done_d;
    logic          pre_clr, pre_en, pre_tc;
    logic          start_ok, key_ok;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tc    (pre_tc)
    );

    // A preset is cookable when non-zero with a valid seconds-tens digit.
    assign start_ok = door_closed && (entry_q != 16'h0000) &&
                      (entry_q[7:4] <= SEC_TENS_MAX);
    assign key_ok   = key_valid && (key_digit <= KEY_DIGIT_MAX);

    // Next-state and registered-output logic; priority stop > door > start > key.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        hold_d   = hold_q;
        loadn_d  = 1'b1;
        clrn_d   = 1'b1;
        tmr_en_d = 1'b0;
        pre_clr  = 1'b0;
        pre_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_SET: begin
                if (stop_clear) begin
                    entry_d = 16'h0000;
                    state_d = ST_IDLE;
                    if (state_q == ST_SET) clrn_d = 1'b0;
                end else if (start && (state_q == ST_SET) && start_ok) begin
                    loadn_d = 1'b0;
                    pre_clr = 1'b1;
                    state_d = ST_COOK;
                end else if (key_ok) begin
                    entry_d = {entry_q[11:0], key_digit};
                    state_d = ST_SET;
                end
            end
            ST_COOK: begin
                if (stop_clear || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (timer_zero && loadn_q) begin
                    // During the load cycle timer_zero still shows the old value.
                    state_d = ST_DONE;
                    pre_clr = 1'b1;
                    hold_d  = '0;
                end else begin
                    pre_en   = 1'b1;
                    tmr_en_d = pre_tc;
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    entry_d = 16'h0000;
                    clrn_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clear) begin
                    state_d = ST_IDLE;
                end else begin
                    pre_en = 1'b1;
                    if (pre_tc) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mag_d  = (state_d == ST_COOK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset holds the timer cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            entry_q  <= 16'h0000;
            hold_q   <= '0;
            loadn_q  <= 1'b1;
            clrn_q   <= 1'b0;
            tmr_en_q <= 1'b0;
            mag_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            hold_q   <= hold_d;
            loadn_q  <= loadn_d;
            clrn_q   <= clrn_d;
            tmr_en_q <= tmr_en_d;
            mag_q    <= mag_d;
            done_q   <= done_d;
        end
    end

    assign entry        = entry_q;
    assign timer_loadn  = loadn_q;
    assign timer_clrn   = clrn_q;
    assign timer_enable = tmr_en_q;
    assign magnetron    = mag_q;
    assign done_flag    = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer with a cycle-level behavioural model.
module tb_cook_sequencer;

    localparam int TD = 4;
    localparam int DH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop_clear, door_closed, key_valid, timer_zero;
    logic [3:0]  key_digit;
    logic [15:0] entry;
    logic        timer_loadn, timer_clrn, timer_enable, magnetron, done_flag;
    logic [2:0]  state;

    int n_checks;
    int n_errors;
    int cyc = 0;
    bit cmp_on;

    cook_sequencer #(.TICK_DIV(TD), .DONE_HOLD(DH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .timer_zero   (timer_zero),
        .entry        (entry),
        .timer_loadn  (timer_loadn),
        .timer_clrn   (timer_clrn),
        .timer_enable (timer_enable),
        .magnetron    (magnetron),
        .done_flag    (done_flag),
        .state        (state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=%0h req=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: states as integers, cook progress as a phase modulo TD,
    // DONE length as a plain count of cycles.
    int          m_state, m_nxt, m_phase, m_done_cyc;
    logic [15:0] m_entry;
    bit          e_loadn, e_clrn, e_en, just_loaded;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_entry = 16'h0; m_phase = 0; m_done_cyc = 0;
            e_loadn = 1; e_clrn = 0; e_en = 0;
        end else begin
            m_nxt = m_state;
            just_loaded = !e_loadn;
            e_loadn = 1; e_clrn = 1; e_en = 0;
            if (m_state == 0 || m_state == 1) begin
                if (stop_clear) begin
                    if (m_state == 1) e_clrn = 0;
                    m_entry = 16'h0; m_nxt = 0;
                end else if (m_state == 1 && start && door_closed && m_entry != 16'h0
                             && m_entry[7:4] <= 4'd5) begin
                    e_loadn = 0; m_phase = 0; m_nxt = 2;
                end else if (key_valid && key_digit < 4'd10) begin
                    m_entry = {m_entry[11:0], key_digit}; m_nxt = 1;
                end
            end else if (m_state == 2) begin
                if (stop_clear || !door_closed) begin
                    m_nxt = 3;
                end else if (timer_zero && !just_loaded) begin
                    m_nxt = 4; m_done_cyc = 0;
                end else begin
                    if (m_phase == TD - 1) e_en = 1;
                    m_phase = (m_phase + 1) % TD;
                end
            end else if (m_state == 3) begin
                if (stop_clear) begin
                    e_clrn = 0; m_entry = 16'h0; m_nxt = 0;
                end else if (start && door_closed) begin
                    m_nxt = 2;
                end
            end else begin
                if (stop_clear) begin
                    m_nxt = 0;
                end else begin
                    m_done_cyc++;
                    if (m_done_cyc == TD * DH) m_nxt = 0;
                end
            end
            m_state = m_nxt;
        end
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("m_state",     32'(state),        32'(m_state));
            chk("m_entry",     32'(entry),        32'(m_entry));
            chk("m_loadn",     32'(timer_loadn),  32'(e_loadn));
            chk("m_clrn",      32'(timer_clrn),   32'(e_clrn));
            chk("m_enable",    32'(timer_enable), 32'(e_en));
            chk("m_magnetron", 32'(magnetron),    32'(m_state == 2));
            chk("m_done",      32'(done_flag),    32'(m_state == 4));
        end
    end

    // Driver tasks: inputs change only on the falling edge.
    task automatic key(input int d);
        @(negedge clock); key_valid = 1'b1; key_digit = 4'(d);
        @(negedge clock); key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clock); stop_clear = 1'b1;
        @(negedge clock); stop_clear = 1'b0;
    endtask

    task automatic wait_en(output int at);
        int n;
        n = 0;
        @(negedge clock);
        while (timer_enable !== 1'b1 && n < 40) begin
            @(negedge clock); n++;
        end
        at = (timer_enable === 1'b1) ? cyc : -1;
    endtask

    task automatic count_done(output int n);
        n = 0;
        while (done_flag === 1'b1 && n < 40) begin
            n++; @(negedge clock);
        end
    endtask

    int c0, t, n;

    initial begin
        reset = 1; start = 0; stop_clear = 0; door_closed = 1;
        key_valid = 0; key_digit = 0; timer_zero = 0;
        n_checks = 0; n_errors = 0; cmp_on = 0;
        repeat (2) @(negedge clock);
        cmp_on = 1;
        @(negedge clock);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clrn", 32'(timer_clrn), 32'd0);
        chk("rst_loadn", 32'(timer_loadn), 32'd1);
        reset = 0;
        @(negedge clock);
        chk("clrn_rise", 32'(timer_clrn), 32'd1);

        // Normal cook: 00:03
        key(0); key(0); key(0); key(3);
        chk("entry_0003", 32'(entry), 32'h0003);
        chk("set_state", 32'(state), 32'd1);
        timer_zero = 1;                      // timer still cleared during load
        pulse_start(); c0 = cyc;
        chk("loadn_low", 32'(timer_loadn), 32'd0);
        chk("cook_state", 32'(state), 32'd2);
        @(negedge clock);
        chk("load_cycle_no_done", 32'(state), 32'd2);
        chk("loadn_one_cycle", 32'(timer_loadn), 32'd1);
        timer_zero = 0;
        wait_en(t); chk("en1_lat", 32'(t - c0), 32'd4);
        wait_en(t); chk("en2_lat", 32'(t - c0), 32'd8);
        wait_en(t); chk("en3_lat", 32'(t - c0), 32'd12);
        timer_zero = 1;
        @(negedge clock);
        chk("done_state", 32'(state), 32'd4);
        chk("done_mag_off", 32'(magnetron), 32'd0);
        count_done(n);
        chk("done_len", 32'(n), 32'd8);
        chk("done_to_idle", 32'(state), 32'd0);
        chk("entry_kept", 32'(entry), 32'h0003);
        timer_zero = 0;

        // Rejection cases
        pulse_stop();
        chk("idle_clear", 32'(entry), 32'h0000);
        key(0); key(0); key(7); key(0);
        pulse_start();
        chk("rej_sec_tens", 32'(state), 32'd1);
        key(10);
        chk("key10_ignored", 32'(entry), 32'h0070);
        pulse_stop();
        chk("set_stop_clrn", 32'(timer_clrn), 32'd0);
        chk("set_stop_state", 32'(state), 32'd0);
        @(negedge clock);
        chk("set_stop_clrn_rise", 32'(timer_clrn), 32'd1);
        key(0);
        pulse_start();
        chk("rej_zero", 32'(state), 32'd1);
        key(5);
        door_closed = 0;
        pulse_start();
        chk("rej_door", 32'(state), 32'd1);
        door_closed = 1;

        // Door pause and resume
        pulse_start(); c0 = cyc;
        wait_en(t); chk("p_en1_lat", 32'(t - c0), 32'd4);
        repeat (2) @(negedge clock);
        door_closed = 0;
        @(negedge clock);
        chk("pause_state", 32'(state), 32'd3);
        chk("pause_mag", 32'(magnetron), 32'd0);
        repeat (4) @(negedge clock);
        door_closed = 1;
        pulse_start(); c0 = cyc;
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_noload", 32'(timer_loadn), 32'd1);
        wait_en(t); chk("resume_lat", 32'(t - c0), 32'd2);

        // Clear from PAUSE, then start+stop in SET
        door_closed = 0;
        @(negedge clock);
        chk("pause2_state", 32'(state), 32'd3);
        door_closed = 1;
        pulse_stop();
        chk("pause_stop_clrn", 32'(timer_clrn), 32'd0);
        chk("pause_stop_entry", 32'(entry), 32'h0000);
        chk("pause_stop_state", 32'(state), 32'd0);
        @(negedge clock);
        chk("pause_stop_clrn_rise", 32'(timer_clrn), 32'd1);
        key(1); key(2);
        @(negedge clock); start = 1; stop_clear = 1;
        @(negedge clock); start = 0; stop_clear = 0;
        chk("both_state", 32'(state), 32'd0);
        chk("both_entry", 32'(entry), 32'h0000);
        chk("both_noload", 32'(timer_loadn), 32'd1);

        // Keys ignored in COOK and DONE; stop in DONE
        key(0); key(1); key(0); key(0);
        pulse_start();
        key(9);
        chk("cook_key_ignored", 32'(entry), 32'h0100);
        timer_zero = 1;
        @(negedge clock);
        chk("done2_state", 32'(state), 32'd4);
        key(7);
        chk("done_key_ignored", 32'(entry), 32'h0100);
        pulse_stop();
        chk("done_stop_state", 32'(state), 32'd0);
        chk("done_stop_flag", 32'(done_flag), 32'd0);
        timer_zero = 0;

        // Asynchronous reset mid-cook
        key(0);
        chk("entry_shift", 32'(entry), 32'h1000);
        pulse_start();
        repeat (2) @(negedge clock);
        #2 reset = 1;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_entry", 32'(entry), 32'h0000);
        chk("ar_mag", 32'(magnetron), 32'd0);
        chk("ar_clrn", 32'(timer_clrn), 32'd0);
        chk("ar_loadn", 32'(timer_loadn), 32'd1);
        chk("ar_en", 32'(timer_enable), 32'd0);
        chk("ar_done", 32'(done_flag), 32'd0);
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("ar_clrn_rise", 32'(timer_clrn), 32'd1);
        @(negedge clock);
        cmp_on = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
